spike_event_sequencer: RTL and testbench

- Upstream feeder for the tick generator and the tinyODIN core.
- Buffers host-supplied input spike events, each tagged with a target tick, in a FIFO.
- On each tick it replays every event stamped with the current tick into ODIN over the 4-phase AER input handshake.
- It then asserts spikecore_done_o, which the tick generator ANDs with ODIN's done to advance the tick.

---
 rtl/spike_seq_pkg.sv | 20 ++
 rtl/spike_event_fifo.sv | 55 +++++
 rtl/spike_event_sequencer.sv | 140 ++++++++++++++
 tb/tb_spike_event_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_seq_pkg.sv
// Shared types and widths for the spike event sequencer.
package spike_seq_pkg;
    localparam int SEQ_N          = 256;
    localparam int SEQ_TICK_W     = 8;
    localparam int SEQ_ADDR_W     = $clog2(SEQ_N);
    localparam int SEQ_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [SEQ_TICK_W-1:0] tick;
        logic [SEQ_ADDR_W-1:0] addr;
    } spike_evt_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        ACK_LO,
        DONE
    } seq_state_e;
endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous FIFO of tick-stamped spike events with occupancy count.
module spike_event_fifo
    import spike_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  spike_evt_t    din,
    input  logic          pop,
    output spike_evt_t    head,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [CW-1:0] cnt_nxt
);
    localparam int PW = $clog2(DEPTH);

    spike_evt_t    mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          wr;
    logic          rd;

    assign empty = (count == '0);
    assign wr    = push && (count != CW'(DEPTH));
    assign rd    = pop && !empty;
    assign head  = mem[rp];

    always_comb begin
        cnt_nxt = count;
        if (wr && !rd)
            cnt_nxt = count + 1'b1;
        else if (rd && !wr)
            cnt_nxt = count - 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= cnt_nxt;
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (wr) mem[wp] <= din;
    end
endmodule

// File: rtl/spike_event_sequencer.sv
// Replays host spike events stamped with the current tick into ODIN
// over the 4-phase AER handshake, then signals tick completion.
module spike_event_sequencer
    import spike_seq_pkg::*;
#(
    parameter int N          = SEQ_N,
    parameter int FIFO_DEPTH = SEQ_FIFO_DEPTH,
    parameter int TICK_W     = SEQ_TICK_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    input  logic [TICK_W-1:0]             push_tick_i,
    input  logic [$clog2(N)-1:0]          push_addr_i,
    input  logic                          inference_start_i,
    input  logic                          inference_done_i,
    input  logic [TICK_W-1:0]             tick_i,
    input  logic                          next_tick_i,
    output logic [$clog2(N)-1:0]          AERIN_ADDR_o,
    output logic                          AERIN_REQ_o,
    input  logic                          AERIN_ACK_i,
    output logic                          spikecore_done_o,
    output logic                          late_drop_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_e    state;
    seq_state_e    state_n;
    spike_evt_t    push_evt;
    spike_evt_t    head;
    logic          empty;
    logic          push;
    logic          pop;
    logic          load;
    logic          drop;
    logic          abort_q;
    logic          abort_n;
    logic          rdy_q;
    logic          req_q;
    logic          done_q;
    logic          drop_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] cnt_nxt;

    assign push_evt = '{tick: push_tick_i, addr: push_addr_i};
    assign push     = push_valid_i && rdy_q;

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (push),
        .din     (push_evt),
        .pop     (pop),
        .head    (head),
        .empty   (empty),
        .count   (fifo_count_o),
        .cnt_nxt (cnt_nxt)
    );

    always_comb begin
        state_n = state;
        abort_n = abort_q;
        pop     = 1'b0;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state)
            IDLE: begin
                if (inference_start_i && !inference_done_i)
                    state_n = CHECK;
            end
            CHECK: begin
                if (inference_done_i) begin
                    state_n = IDLE;
                end else if (empty || head.tick > tick_i) begin
                    state_n = DONE;
                end else if (head.tick < tick_i) begin
                    pop  = 1'b1;
                    drop = 1'b1;
                end else begin
                    load    = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (inference_done_i) abort_n = 1'b1;
                if (AERIN_ACK_i) begin
                    pop     = 1'b1;
                    state_n = ACK_LO;
                end
            end
            ACK_LO: begin
                if (inference_done_i) abort_n = 1'b1;
                // A pending abort only takes effect once ODIN drops ack.
                if (!AERIN_ACK_i) begin
                    state_n = abort_n ? IDLE : CHECK;
                    abort_n = 1'b0;
                end
            end
            DONE: begin
                if (inference_done_i)
                    state_n = IDLE;
                else if (next_tick_i)
                    state_n = CHECK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            abort_q <= 1'b0;
            rdy_q   <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state   <= state_n;
            abort_q <= abort_n;
            rdy_q   <= (cnt_nxt != CW'(FIFO_DEPTH));
            req_q   <= (state_n == REQ);
            done_q  <= (state == DONE) && (state_n == DONE);
            drop_q  <= drop;
            if (load) addr_q <= head.addr;
        end
    end

    assign push_ready_o     = rdy_q;
    assign AERIN_REQ_o      = req_q;
    assign AERIN_ADDR_o     = addr_q;
    assign spikecore_done_o = done_q;
    assign late_drop_o      = drop_q;
endmodule

// File: tb/tb_spike_event_sequencer.sv
// Directed bench for spike_event_sequencer with a small ODIN ack model.
module tb_spike_event_sequencer;
    logic       CLK;
    logic       RST;
    logic       push_valid_i;
    logic       push_ready_o;
    logic [7:0] push_tick_i;
    logic [7:0] push_addr_i;
    logic       inference_start_i;
    logic       inference_done_i;
    logic [7:0] tick_i;
    logic       next_tick_i;
    logic [7:0] AERIN_ADDR_o;
    logic       AERIN_REQ_o;
    logic       AERIN_ACK_i;
    logic       spikecore_done_o;
    logic       late_drop_o;
    logic [4:0] fifo_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic odin_en;
    logic model_ack;
    logic man_ack;
    int   req_age;
    int   delivered [$];
    int   n_drop = 0;
    int   viol   = 0;
    logic req_prev  = 1'b0;
    logic ack_prev  = 1'b0;
    logic [7:0] addr_prev = '0;

    assign AERIN_ACK_i = odin_en ? model_ack : man_ack;

    spike_event_sequencer dut (
        .CLK               (CLK),
        .RST               (RST),
        .push_valid_i      (push_valid_i),
        .push_ready_o      (push_ready_o),
        .push_tick_i       (push_tick_i),
        .push_addr_i       (push_addr_i),
        .inference_start_i (inference_start_i),
        .inference_done_i  (inference_done_i),
        .tick_i            (tick_i),
        .next_tick_i       (next_tick_i),
        .AERIN_ADDR_o      (AERIN_ADDR_o),
        .AERIN_REQ_o       (AERIN_REQ_o),
        .AERIN_ACK_i       (AERIN_ACK_i),
        .spikecore_done_o  (spikecore_done_o),
        .late_drop_o       (late_drop_o),
        .fifo_count_o      (fifo_count_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ODIN model: ack three cycles into a request, release after req falls.
    initial begin
        model_ack = 1'b0;
        req_age   = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST || !odin_en) begin
                model_ack = 1'b0;
                req_age   = 0;
            end else if (AERIN_REQ_o && !model_ack) begin
                req_age++;
                if (req_age >= 3) begin
                    model_ack = 1'b1;
                    delivered.push_back(int'(AERIN_ADDR_o));
                end
            end else if (!AERIN_REQ_o && model_ack) begin
                model_ack = 1'b0;
                req_age   = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (late_drop_o) n_drop++;
            if (req_prev && !AERIN_REQ_o && !ack_prev) viol++;
            if (req_prev && AERIN_REQ_o && AERIN_ADDR_o != addr_prev) viol++;
        end
        req_prev  = AERIN_REQ_o;
        ack_prev  = AERIN_ACK_i;
        addr_prev = AERIN_ADDR_o;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input int t, input int a);
        push_valid_i = 1'b1;
        push_tick_i  = 8'(t);
        push_addr_i  = 8'(a);
        tick(1);
        push_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        inference_start_i = 1'b1;
        tick(1);
        inference_start_i = 1'b0;
    endtask

    task automatic pulse_done();
        inference_done_i = 1'b1;
        tick(1);
        inference_done_i = 1'b0;
    endtask

    task automatic pulse_next(input int t);
        tick_i      = 8'(t);
        next_tick_i = 1'b1;
        tick(1);
        next_tick_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!spikecore_done_o && k < 300) begin
            tick(1);
            k++;
        end
        check(tag, int'(spikecore_done_o), 1);
    endtask

    function automatic int dl(input int i);
        return (i < delivered.size()) ? delivered[i] : -1;
    endfunction

    int base;
    int d0;

    initial begin
        RST               = 1'b1;
        push_valid_i      = 1'b0;
        push_tick_i       = '0;
        push_addr_i       = '0;
        inference_start_i = 1'b0;
        inference_done_i  = 1'b0;
        tick_i            = '0;
        next_tick_i       = 1'b0;
        man_ack           = 1'b0;
        odin_en           = 1'b0;

        tick(1);
        check("rst_req", int'(AERIN_REQ_o), 0);
        check("rst_addr", int'(AERIN_ADDR_o), 0);
        check("rst_done", int'(spikecore_done_o), 0);
        check("rst_drop", int'(late_drop_o), 0);
        check("rst_count", int'(fifo_count_o), 0);
        check("rst_ready", int'(push_ready_o), 0);
        RST = 1'b0;
        tick(1);
        check("ready_after_rst", int'(push_ready_o), 1);

        // reset while a request is outstanding
        push(0, 1);
        check("mid_count", int'(fifo_count_o), 1);
        pulse_start();
        tick(1);
        check("latency_req", int'(AERIN_REQ_o), 1);
        check("latency_addr", int'(AERIN_ADDR_o), 1);
        #3 RST = 1'b1;
        #1;
        check("midrst_req", int'(AERIN_REQ_o), 0);
        check("midrst_done", int'(spikecore_done_o), 0);
        check("midrst_count", int'(fifo_count_o), 0);
        #2 RST = 1'b0;
        tick(1);

        // single tick, two events
        odin_en = 1'b1;
        push(0, 5);
        push(0, 9);
        check("single_count_in", int'(fifo_count_o), 2);
        base = delivered.size();
        d0   = n_drop;
        pulse_start();
        wait_done("single_done");
        check("single_n", delivered.size() - base, 2);
        check("single_a0", dl(base), 5);
        check("single_a1", dl(base + 1), 9);
        check("single_ack_low", int'(AERIN_ACK_i), 0);
        check("single_count", int'(fifo_count_o), 0);
        check("single_drops", n_drop - d0, 0);
        pulse_done();
        check("single_idle_done", int'(spikecore_done_o), 0);

        // future event
        push(2, 7);
        tick_i = 8'd0;
        base   = delivered.size();
        pulse_start();
        tick(1);
        check("future_done_early", int'(spikecore_done_o), 0);
        tick(1);
        check("future_done", int'(spikecore_done_o), 1);
        check("future_noreq", delivered.size() - base, 0);
        pulse_next(1);
        check("future_done_drop", int'(spikecore_done_o), 0);
        wait_done("future_t1_done");
        check("future_t1_noreq", delivered.size() - base, 0);
        pulse_next(2);
        wait_done("future_t2_done");
        check("future_n", delivered.size() - base, 1);
        check("future_addr", dl(base), 7);
        check("future_count", int'(fifo_count_o), 0);
        pulse_done();

        // stale event dropped
        push(1, 3);
        push(4, 8);
        tick_i = 8'd3;
        base   = delivered.size();
        d0     = n_drop;
        pulse_start();
        wait_done("stale_done");
        check("stale_drops", n_drop - d0, 1);
        check("stale_noreq", delivered.size() - base, 0);
        check("stale_count", int'(fifo_count_o), 1);
        pulse_next(4);
        wait_done("stale_t4_done");
        check("stale_addr", dl(base), 8);
        check("stale_drops2", n_drop - d0, 1);
        pulse_done();

        // full FIFO
        odin_en = 1'b0;
        tick_i  = 8'd0;
        for (int i = 0; i < 16; i++) push(0, i);
        check("full_count", int'(fifo_count_o), 16);
        check("full_ready", int'(push_ready_o), 0);
        push(0, 99);
        check("full_reject", int'(fifo_count_o), 16);
        pulse_start();
        tick(1);
        check("full_req", int'(AERIN_REQ_o), 1);
        check("full_addr", int'(AERIN_ADDR_o), 0);
        man_ack = 1'b1;
        tick(1);
        check("full_req_fall", int'(AERIN_REQ_o), 0);
        check("full_ready_back", int'(push_ready_o), 1);
        check("full_count_pop", int'(fifo_count_o), 15);

        // abort during a request
        man_ack = 1'b0;
        tick(2);
        check("abort_req", int'(AERIN_REQ_o), 1);
        check("abort_addr", int'(AERIN_ADDR_o), 1);
        pulse_done();
        check("abort_req_held", int'(AERIN_REQ_o), 1);
        man_ack = 1'b1;
        tick(1);
        check("abort_req_fall", int'(AERIN_REQ_o), 0);
        man_ack = 1'b0;
        tick(4);
        check("abort_idle_req", int'(AERIN_REQ_o), 0);
        check("abort_done", int'(spikecore_done_o), 0);
        check("abort_count", int'(fifo_count_o), 14);

        // restart from IDLE drains the kept events
        odin_en = 1'b1;
        base    = delivered.size();
        pulse_start();
        wait_done("restart_done");
        check("restart_n", delivered.size() - base, 14);
        check("restart_first", dl(base), 2);
        check("restart_count", int'(fifo_count_o), 0);
        check("handshake_viol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
